// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM state type for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 5;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Any opcode above subtract has no defined ALU meaning.
    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        return op > OP_SUB;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the 4-bit ALU: registers operands/opcode toward the ALU,
// captures its result one cycle later and returns it with status flags.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_zero,
    output logic              rsp_cout,
    output logic              rsp_err,
    output logic [7:0]        op_count
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_cmd_fire;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] r_acc;
    logic              r_err;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [RES_W-1:0]  r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_cout;
    logic              r_rsp_err;
    logic [7:0]        r_op_count;

    // Handshake decode; cmd_ready is held low while reset is asserted.
    always_comb begin
        cmd_ready  = rst_n && (r_state == IDLE);
        rsp_valid  = (r_state == RESP);
        w_cmd_fire = cmd_ready && cmd_valid;
        w_rsp_fire = (r_state == RESP) && rsp_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, one settle/capture cycle, then hold until consumed.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_cmd_fire) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (w_rsp_fire) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand issue, result capture, accumulator and completion counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_err      <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_cout <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_alu_a  <= cmd_chain ? r_acc : cmd_a;
                r_alu_b  <= cmd_b;
                r_alu_op <= cmd_op;
                r_err    <= op_reserved(cmd_op);
            end
            if (r_state == EXEC) begin
                r_rsp_err <= r_err;
                if (r_err) begin
                    // Reserved op: report a clean zero and leave the accumulator alone.
                    r_rsp_data <= '0;
                    r_rsp_zero <= 1'b1;
                    r_rsp_cout <= 1'b0;
                end else begin
                    r_rsp_data <= alu_out;
                    r_rsp_zero <= (alu_out[DATA_W-1:0] == '0);
                    r_rsp_cout <= alu_out[RES_W-1];
                    r_acc      <= alu_out[DATA_W-1:0];
                end
            end
            if (w_rsp_fire) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign rsp_data = r_rsp_data;
    assign rsp_zero = r_rsp_zero;
    assign rsp_cout = r_rsp_cout;
    assign rsp_err  = r_rsp_err;
    assign op_count = r_op_count;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 4-bit ALU (alu_4bit). It accepts operand/opcode commands over a valid/ready handshake, drives registered operands and opcode into the ALU, and captures the 5-bit result. It returns the result with status flags over a second valid/ready handshake. It sits between the board-level input logic (switches/buttons or a test driver) and the ALU, and optionally chains the previous result in as the next operand A.

## Interface
- No parameters; widths fixed: operand 4 bits, opcode 3 bits, result 5 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_a  in  4  operand A (ignored when cmd_chain=1)
- cmd_b  in  4  operand B
- cmd_op  in  3  opcode (000 add, 001 subtract, others reserved)
- cmd_chain  in  1  use held accumulator as operand A
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_out  in  5  ALU combinational result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  5  captured ALU result
- rsp_zero  out  1  rsp_data[3:0] == 0
- rsp_cout  out  1  rsp_data[4] (carry on add, borrow on subtract)
- rsp_err  out  1  opcode was reserved
- op_count  out  8  completed responses, wraps 255→0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: load alu_a (cmd_a, or acc when cmd_chain=1), alu_b=cmd_b, alu_op=cmd_op; latch err_q = (cmd_op > 3'b001); go to EXEC.
- EXEC: cmd_ready=0. ALU output settles; capture rsp_data=alu_out (forced 5'b0 if err_q), rsp_zero, rsp_cout, rsp_err=err_q; set rsp_valid=1; update acc = captured rsp_data[3:0] unless err_q (acc unchanged on error); go to RESP.
- RESP: cmd_ready=0, rsp_valid=1, all rsp_* held stable. On rsp_ready: rsp_valid→0, op_count+1 (mod 256), go to IDLE.
- Reserved opcode: still issued to ALU (alu_op carries it); response data 0, rsp_err=1, rsp_zero=1, rsp_cout=0; counts toward op_count.
- Arithmetic: no width extension inside the block; rsp_data is exactly the ALU's 5-bit value. Chain uses only bits [3:0] of the previous result.
- acc reset value 0; chain on first command after reset uses A=0.

## Timing
- Reset (rst_n low at a clk edge): state=IDLE, cmd_ready=0 while rst_n low, then 1 from first cycle after release; alu_a/alu_b/alu_op=0; rsp_valid=0; rsp_data=0; rsp_zero/rsp_cout/rsp_err=0; op_count=0; acc=0.
- Command accepted at edge N → alu_* valid after N; response captured at edge N+1, rsp_valid high after N+1.
- rsp_ready high on arrival → handshake at N+2, IDLE after N+2; next command accepted earliest at N+3. Max throughput 1 op / 3 cycles.
- rsp_ready held high in IDLE/EXEC has no effect.
- cmd_valid ignored when cmd_ready=0; cmd_* need be stable only at the accepting edge.
- Back-pressure: RESP holds indefinitely; alu_* outputs stay at last command.
- Reset mid-EXEC or mid-RESP: transaction dropped, no op_count increment, acc cleared.

## Structure
- Package alu_pkg: op constants OP_ADD=3'b000, OP_SUB=3'b001; state enum typedef (IDLE, EXEC, RESP); widths DATA_W=4, RES_W=5, OP_W=3.
- Single module, no sub-modules; the ALU instance lives in the parent alongside this block, and the bench instantiates both.

## Test plan
- Reset then add: a=5,b=3,op=000 → rsp_data=5'b01000, zero=0, cout=0, err=0, rsp_valid 2 edges after accept, op_count=1.
- Add overflow: a=15,b=1 → rsp_data=5'b10000, zero=1, cout=1.
- Subtract with borrow: a=2,b=5,op=001 → rsp_data equals ALU's 5-bit subtract value; cout=bit4; then cmd_chain=1,b=1,op=000 → alu_a equals previous rsp_data[3:0].
- Reserved op 3'b101 → rsp_err=1, rsp_data=0, zero=1, acc unchanged (next chained command uses prior acc).
- Back-pressure: rsp_ready low 10 cycles → rsp_* stable, cmd_ready=0, cmd_valid pulses ignored; release → single handshake, op_count+1.
- Reset asserted during RESP → rsp_valid=0 next edge, op_count and acc =0; 256 back-to-back ops → op_count wraps to 0.
